// File: rtl/batch_sched_ctrl.sv
// Ping-pong batch scheduler: buffers control-bit samples and replays each batch ascending and descending.
// Optional flush/pad/drain path is compiled in when BATCH_FLUSH_EN is defined.
module batch_sched_ctrl #(
  parameter int N     = 3,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
`ifdef BATCH_FLUSH_EN
  input  logic         flush,
`endif
  output logic [N-1:0] fwd_sample,
  output logic         fwd_valid,
  output logic [N-1:0] bwd_sample,
  output logic         bwd_valid,
  output logic         bwd_clear,
  output logic         batch_done
);
  localparam int CW = $clog2(DEPTH);
  localparam int AW = $clog2(2 * DEPTH);
  localparam logic [CW-1:0] LAST     = CW'(DEPTH - 1);
  localparam logic [AW-1:0] BANK_OFS = AW'(DEPTH);

  typedef enum logic [1:0] {FILL, RUN, PAD, DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_wr_bank;
  logic [N-1:0]  r_store [2*DEPTH];
  logic [N-1:0]  r_fwd_sample;
  logic [N-1:0]  r_bwd_sample;
  logic          r_fwd_valid;
  logic          r_bwd_clear;
  logic          r_batch_done;

  logic          w_step;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_last;
  logic [N-1:0]  w_wr_data;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_fwd_idx;
  logic [AW-1:0] w_bwd_idx;

  assign w_last    = (r_cnt == LAST);
  assign w_wr_idx  = (r_wr_bank ? BANK_OFS : '0) + AW'(r_cnt);
  // The read bank is always the one not being written, so reads never collide with the write.
  assign w_fwd_idx = (r_wr_bank ? '0 : BANK_OFS) + AW'(r_cnt);
  assign w_bwd_idx = (r_wr_bank ? '0 : BANK_OFS) + AW'(LAST - r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_step       = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_wr_data    = in;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        w_step   = in_valid;
        w_wr_en  = in_valid;
        if (in_valid && w_last) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        w_step   = in_valid;
        w_wr_en  = in_valid;
        w_rd_en  = in_valid;
`ifdef BATCH_FLUSH_EN
        // A flush on the closing step of a batch has nothing left to pad.
        if (flush) begin
          w_state_next = (in_valid && w_last) ? DRAIN : PAD;
        end
`endif
      end
`ifdef BATCH_FLUSH_EN
      PAD: begin
        w_step    = 1'b1;
        w_wr_en   = 1'b1;
        w_rd_en   = 1'b1;
        w_wr_data = '0;
        if (w_last) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_step  = 1'b1;
        w_rd_en = 1'b1;
        if (w_last) begin
          w_state_next = FILL;
        end
      end
`endif
      default: w_state_next = FILL;
    endcase
  end

  // Store contents need no reset: nothing is read before a full batch is written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_store[w_wr_idx] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_wr_bank    <= 1'b0;
      r_fwd_sample <= '0;
      r_bwd_sample <= '0;
      r_fwd_valid  <= 1'b0;
      r_bwd_clear  <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      r_fwd_valid  <= w_rd_en;
      r_bwd_clear  <= w_rd_en && (r_cnt == '0);
      r_batch_done <= w_rd_en && w_last;
      if (w_rd_en) begin
        r_fwd_sample <= r_store[w_fwd_idx];
        r_bwd_sample <= r_store[w_bwd_idx];
      end
      if (w_step) begin
        if (w_last) begin
          r_cnt     <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign fwd_sample = r_fwd_sample;
  assign fwd_valid  = r_fwd_valid;
  assign bwd_sample = r_bwd_sample;
  assign bwd_valid  = r_fwd_valid;
  assign bwd_clear  = r_bwd_clear;
  assign batch_done = r_batch_done;

endmodule

// File: tb/tb_batch_sched_ctrl.sv
// Directed bench for batch_sched_ctrl at N=3, DEPTH=4; flush scenarios run when BATCH_FLUSH_EN is defined.
module tb_batch_sched_ctrl;
  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_s;
  logic         in_valid;
  logic         in_ready;
`ifdef BATCH_FLUSH_EN
  logic         flush;
`endif
  logic [N-1:0] fwd_sample;
  logic         fwd_valid;
  logic [N-1:0] bwd_sample;
  logic         bwd_valid;
  logic         bwd_clear;
  logic         batch_done;

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs one cycle after each of 12 back-to-back steps.
  int din   [12] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};
  int exp_v [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  int exp_f [12] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 0};
  int exp_b [12] = '{0, 0, 0, 0, 4, 3, 2, 1, 0, 7, 6, 5};
  int exp_c [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
  int exp_d [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

  always #5 clk = ~clk;

  batch_sched_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_s),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef BATCH_FLUSH_EN
    .flush      (flush),
`endif
    .fwd_sample (fwd_sample),
    .fwd_valid  (fwd_valid),
    .bwd_sample (bwd_sample),
    .bwd_valid  (bwd_valid),
    .bwd_clear  (bwd_clear),
    .batch_done (batch_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v, input int d);
    in_valid = v;
    in_s     = N'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input int v, input int f, input int b, input int c, input int d);
    chk({tag, " fwd_valid"}, 32'(fwd_valid), v);
    chk({tag, " bwd_valid"}, 32'(bwd_valid), v);
    chk({tag, " bwd_clear"}, 32'(bwd_clear), c);
    chk({tag, " batch_done"}, 32'(batch_done), d);
    if (v != 0) begin
      chk({tag, " fwd_sample"}, 32'(fwd_sample), f);
      chk({tag, " bwd_sample"}, 32'(bwd_sample), b);
    end
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_s     = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step_tab(input string tag, input int i);
    tick(1'b1, din[i]);
    look($sformatf("%s s%0d", tag, i), exp_v[i], exp_f[i], exp_b[i], exp_c[i], exp_d[i]);
  endtask

  initial begin
`ifdef BATCH_FLUSH_EN
    flush = 1'b0;
`endif
    // T0: reset state
    do_reset;
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst fwd_sample", 32'(fwd_sample), 0);
    chk("rst bwd_sample", 32'(bwd_sample), 0);
    look("rst", 0, 0, 0, 0, 0);

    // T1: one full batch back-to-back, then idle
    for (int i = 0; i < 8; i++) step_tab("t1", i);
    tick(1'b0, 0);
    look("t1 idle", 0, 0, 0, 0, 0);
    chk("t1 idle hold fwd", 32'(fwd_sample), 4);
    chk("t1 idle hold bwd", 32'(bwd_sample), 1);

    // T2: same data, gap every other cycle; samples hold across gaps
    do_reset;
    for (int i = 0; i < 8; i++) begin
      step_tab("t2", i);
      tick(1'b0, 7);
      look($sformatf("t2 gap%0d", i), 0, 0, 0, 0, 0);
      chk($sformatf("t2 gap%0d hold fwd", i), 32'(fwd_sample), exp_f[i]);
      chk($sformatf("t2 gap%0d hold bwd", i), 32'(bwd_sample), exp_b[i]);
    end

    // T3: twelve samples, bank wraps twice
    do_reset;
    for (int i = 0; i < 12; i++) step_tab("t3", i);

    // T4: reset in the middle of the second batch returns to FILL
    do_reset;
    for (int i = 0; i < 7; i++) step_tab("t4", i);
    rst = 1'b1;
    tick(1'b0, 0);
    rst = 1'b0;
    look("t4 rst", 0, 0, 0, 0, 0);
    chk("t4 rst in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 8; i++) step_tab("t4 refill", i);

`ifdef BATCH_FLUSH_EN
    // T5: flush after six samples pads with zeros and drains
    do_reset;
    for (int i = 0; i < 6; i++) step_tab("t5", i);
    begin
      int fv [7] = '{0, 1, 1, 1, 1, 1, 1};
      int ff [7] = '{0, 3, 4, 5, 6, 0, 0};
      int fb [7] = '{0, 2, 1, 0, 0, 6, 5};
      int fc [7] = '{0, 0, 0, 1, 0, 0, 0};
      int fd [7] = '{0, 0, 1, 0, 0, 0, 1};
      int fr [7] = '{0, 0, 0, 0, 0, 0, 1};
      flush = 1'b1;
      for (int k = 0; k < 7; k++) begin
        tick(1'b0, 0);
        look($sformatf("t5 flush c%0d", k), fv[k], ff[k], fb[k], fc[k], fd[k]);
        chk($sformatf("t5 flush c%0d in_ready", k), 32'(in_ready), fr[k]);
      end
      flush = 1'b0;
      tick(1'b0, 0);
      look("t5 after", 0, 0, 0, 0, 0);
      chk("t5 after in_ready", 32'(in_ready), 1);
    end

    // T6: flush during FILL has no effect
    do_reset;
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_tab("t6 fill", i);
      chk($sformatf("t6 fill s%0d in_ready", i), 32'(in_ready), 1);
    end
    flush = 1'b0;
    for (int i = 4; i < 8; i++) step_tab("t6 run", i);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
